// File: rtl/strtstop_debounce.sv
// strtstop_debounce
//   Conditions the raw STRTSTOP push-button before it reaches the stopwatch
//   control FSM. BTN_RAW is normalised to active-high and passed through a
//   2-flop synchronizer. A debounce FSM then accepts a press or a release only
//   after the synchronized level has been stable for DEBOUNCE_CYCLES cycles.
//
//   Ports
//     CLK          in   system clock (DCM CLK0 domain)
//     RESET        in   asynchronous active-low reset
//     BTN_RAW      in   raw button pin, asynchronous to CLK
//     PRESS_PULSE  out  one-cycle strobe per accepted press
//     LEVEL        out  debounced level, 1 = pressed
//     LONG_PRESS   out  one-cycle strobe when a press is held HOLD_CYCLES
//     BUSY         out  1 while a press or release is being qualified
//
//   Optional feature: define HOLD_DETECT_EN to build the long-press hold
//   counter. Without it LONG_PRESS is tied to 0 and the port list is unchanged.
module strtstop_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int HOLD_CYCLES     = 60000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_RAW,
  output logic PRESS_PULSE,
  output logic LEVEL,
  output logic LONG_PRESS,
  output logic BUSY
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn;
  logic             s1, s2;

  // Normalise to 1 = pressed so the reset value of the sync flops is "released".
  assign btn = BTN_ACTIVE_LOW ? ~BTN_RAW : BTN_RAW;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debounce FSM. The qualification counter is cleared on every state change,
  // so it can never wrap. A disagreeing s2 on the final count cycle wins.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      PRESS_PULSE <= 1'b0;
      LEVEL       <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      PRESS_PULSE <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
            BUSY  <= 1'b1;
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
            cnt   <= '0;
            BUSY  <= 1'b0;
          end else if (cnt == DB_LAST) begin
            state       <= HELD;
            cnt         <= '0;
            PRESS_PULSE <= 1'b1;
            LEVEL       <= 1'b1;
            BUSY        <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
            BUSY  <= 1'b1;
          end
        end
        RELEASE_WAIT: begin
          // Release bounce returns to HELD without a new pulse; LEVEL stays 1.
          if (s2) begin
            state <= HELD;
            cnt   <= '0;
            BUSY  <= 1'b0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            LEVEL <= 1'b0;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          LEVEL <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HOLD_DETECT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_done;

  // Counts cycles spent in HELD. Paused (not cleared) in RELEASE_WAIT so a
  // release bounce keeps the accumulated hold time; cleared whenever the
  // debounced level is low (IDLE / PRESS_WAIT), which covers both entry to
  // HELD and leaving the pressed states. hold_done makes the strobe one-shot
  // and holds the counter saturated.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hold_cnt   <= '0;
      hold_done  <= 1'b0;
      LONG_PRESS <= 1'b0;
    end else begin
      LONG_PRESS <= 1'b0;
      if (state == HELD) begin
        if (!hold_done) begin
          if (hold_cnt == HOLD_LAST) begin
            LONG_PRESS <= 1'b1;
            hold_done  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      end else if (state != RELEASE_WAIT) begin
        hold_cnt  <= '0;
        hold_done <= 1'b0;
      end
    end
  end
`else
  assign LONG_PRESS = 1'b0;

  // Keeps HOLD_CYCLES referenced in the build without the hold counter.
  logic unused_hold;
  assign unused_hold = ^(32'(HOLD_CYCLES));
`endif

endmodule

// File: tb/tb_strtstop_debounce.sv
// tb_strtstop_debounce
//   Directed bench for strtstop_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10,
//   BTN_ACTIVE_LOW=1. A run-length model of the debouncer (the level flips once
//   the synchronized sample has disagreed with it for DEBOUNCE_CYCLES+1
//   consecutive edges) is compared against the outputs every cycle, and
//   hand-computed event offsets are checked per scenario.
module tb_strtstop_debounce;
  localparam int D = 4;
  localparam int H = 10;

  logic CLK     = 1'b0;
  logic RESET   = 1'b0;
  logic BTN_RAW = 1'b1;
  logic PRESS_PULSE, LEVEL, LONG_PRESS, BUSY;

  strtstop_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(16),
    .BTN_ACTIVE_LOW(1'b1),
    .HOLD_CYCLES(H)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .BTN_RAW(BTN_RAW),
    .PRESS_PULSE(PRESS_PULSE),
    .LEVEL(LEVEL),
    .LONG_PRESS(LONG_PRESS),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int edge_no = 0;
  always @(posedge CLK) edge_no <= edge_no + 1;

  // Behavioural model: run = consecutive synchronized samples disagreeing
  // with the debounced level; held = edges spent pressed and not qualifying.
  bit m_s1, m_s2, m_level, m_pulse, m_busy, m_long;
  int m_run, m_held;

  always @(posedge CLK or negedge RESET) begin
    bit lvl, pls, lng;
    int run, held;
    if (!RESET) begin
      m_s1 <= 0; m_s2 <= 0; m_level <= 0; m_pulse <= 0;
      m_busy <= 0; m_long <= 0; m_run <= 0; m_held <= 0;
    end else begin
      lvl = m_level; run = m_run; held = m_held; pls = 0; lng = 0;
      if (lvl && run == 0) begin
        held = held + 1;
`ifdef HOLD_DETECT_EN
        lng = (held == H);
`endif
      end
      if (!lvl) held = 0;
      if (m_s2 != lvl) begin
        run = run + 1;
        if (run == D + 1) begin
          lvl = m_s2;
          run = 0;
          pls = m_s2;
        end
      end else begin
        run = 0;
      end
      m_level <= lvl; m_run <= run; m_held <= held;
      m_pulse <= pls; m_long <= lng; m_busy <= (run != 0);
      m_s2 <= m_s1;
      m_s1 <= !BTN_RAW;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0, pulse_edge = 0, fall_cnt = 0, fall_edge = 0;
  int long_cnt = 0, long_edge = 0, busy_cnt = 0;
  bit prev_lvl = 0;
  int mark, p0, f0, l0, b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: outputs compared 2 time units after the edge, then events logged.
  task automatic step();
    @(posedge CLK);
    #2;
    n_tests++;
    if ({PRESS_PULSE, LEVEL, BUSY, LONG_PRESS} !== {m_pulse, m_level, m_busy, m_long}) begin
      n_fail++;
      $display("FAIL cycle_cmp edge %0d: pulse/level/busy/long got %b%b%b%b expected %b%b%b%b",
               edge_no, PRESS_PULSE, LEVEL, BUSY, LONG_PRESS, m_pulse, m_level, m_busy, m_long);
    end
    if (PRESS_PULSE === 1'b1) begin pulse_cnt++; pulse_edge = edge_no; end
    if (LONG_PRESS === 1'b1) begin long_cnt++; long_edge = edge_no; end
    if (BUSY === 1'b1) busy_cnt++;
    if (prev_lvl && LEVEL === 1'b0) begin fall_cnt++; fall_edge = edge_no; end
    prev_lvl = (LEVEL === 1'b1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    chk("reset_outputs", int'({PRESS_PULSE, LEVEL, BUSY, LONG_PRESS}), 0);
    RESET = 1'b1;
    steps(4);

    // 1: clean press held 20 cycles, then clean release
    p0 = pulse_cnt; mark = edge_no + 1; BTN_RAW = 1'b0;
    steps(20);
    chk("t1_pulse_count", pulse_cnt - p0, 1);
    chk("t1_pulse_cycle", pulse_edge - mark, 6);
    chk("t1_level_held", int'(LEVEL), 1);
    f0 = fall_cnt; mark = edge_no + 1; BTN_RAW = 1'b1;
    steps(10);
    chk("t1_release_falls", fall_cnt - f0, 1);
    chk("t1_release_cycle", fall_edge - mark, 6);
    chk("t1_no_extra_pulse", pulse_cnt - p0, 1);

    // 2: bouncy press (2 low, 1 high, 2 low) is rejected
    p0 = pulse_cnt; b0 = busy_cnt;
    BTN_RAW = 1'b0; steps(2);
    BTN_RAW = 1'b1; steps(1);
    BTN_RAW = 1'b0; steps(2);
    BTN_RAW = 1'b1; steps(10);
    chk("t2_no_pulse", pulse_cnt - p0, 0);
    chk("t2_level_low", int'(LEVEL), 0);
    chk("t2_busy_seen", int'(busy_cnt > b0), 1);

    // Boundary: D pressed samples is one short; D+1 is just enough
    p0 = pulse_cnt;
    BTN_RAW = 1'b0; steps(D);
    BTN_RAW = 1'b1; steps(10);
    chk("bnd_short_no_pulse", pulse_cnt - p0, 0);
    mark = edge_no + 1; BTN_RAW = 1'b0; steps(D + 1);
    BTN_RAW = 1'b1; steps(12);
    chk("bnd_exact_pulse", pulse_cnt - p0, 1);
    chk("bnd_exact_cycle", pulse_edge - mark, 6);

    // 3: held press, release with a 1-cycle pressed glitch
    BTN_RAW = 1'b0; steps(10);
    p0 = pulse_cnt; f0 = fall_cnt;
    BTN_RAW = 1'b1; steps(2);
    BTN_RAW = 1'b0; steps(1);
    mark = edge_no + 1; BTN_RAW = 1'b1;
    steps(12);
    chk("t3_single_fall", fall_cnt - f0, 1);
    chk("t3_fall_cycle", fall_edge - mark, 6);
    chk("t3_no_pulse", pulse_cnt - p0, 0);

    // 4: reset while qualifying a press (cnt=2)
    p0 = pulse_cnt; mark = edge_no + 1; BTN_RAW = 1'b0;
    steps(5);
    chk("t4_busy_before_reset", int'(BUSY), 1);
    RESET = 1'b0; #1;
    chk("t4_outputs_cleared", int'({PRESS_PULSE, LEVEL, BUSY, LONG_PRESS}), 0);
    steps(2);
    BTN_RAW = 1'b1; RESET = 1'b1;
    steps(10);
    chk("t4_no_pulse_after_reset", pulse_cnt - p0, 0);
    mark = edge_no + 1; BTN_RAW = 1'b0; steps(8);
    chk("t4_requalified_pulse", pulse_cnt - p0, 1);
    chk("t4_requalified_cycle", pulse_edge - mark, 6);

    // Reset while HELD drops LEVEL asynchronously
    chk("held_level_before_reset", int'(LEVEL), 1);
    RESET = 1'b0; #1;
    chk("held_level_async_drop", int'(LEVEL), 0);
    steps(2);
    BTN_RAW = 1'b1; RESET = 1'b1;
    steps(5);

    // 5: hold 30 cycles
    p0 = pulse_cnt; l0 = long_cnt; mark = edge_no + 1; BTN_RAW = 1'b0;
    steps(30);
    chk("t5_pulse_count", pulse_cnt - p0, 1);
`ifdef HOLD_DETECT_EN
    chk("t5_long_count", long_cnt - l0, 1);
    chk("t5_long_after_pulse", long_edge - pulse_edge, H);
`else
    chk("t5_long_tied_low", long_cnt - l0, 0);
`endif
    BTN_RAW = 1'b1; steps(10);

    // 6: two clean presses separated by 8 released cycles
    p0 = pulse_cnt; f0 = fall_cnt;
    for (int k = 0; k < 2; k++) begin
      BTN_RAW = 1'b0; steps(8);
      BTN_RAW = 1'b1; steps(8);
      if (k == 0) chk("t6_level_low_between", int'(LEVEL), 0);
    end
    steps(4);
    chk("t6_two_pulses", pulse_cnt - p0, 2);
    chk("t6_two_falls", fall_cnt - f0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
